// File: rtl/vj_sched_pkg.sv
// Shared types for the face-detection scan scheduler: FSM state encoding and the idle level marker.
// No logic lives here; latency and backpressure are defined by the modules that import it.
package vj_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_INT,
      SCAN,
      STEP,
      FIN
   } sched_state_t;

   localparam logic [3:0] LEVEL_IDLE = 4'd15;

endpackage

// File: rtl/window_stepper.sv
// Window-origin row/col counters with per-level scan limits; one step per advance, registered coords.
// Counters hold whenever advance is low, so a stalled consumer sees stable coordinates.
module window_stepper
   import vj_sched_pkg::*;
#(
   parameter int                                PYRAMID_LEVELS = 2,
   parameter int                                WINDOW_SIZE    = 24,
   parameter logic [PYRAMID_LEVELS-1:0][31:0]   LEVEL_WIDTHS   = '0,
   parameter logic [PYRAMID_LEVELS-1:0][31:0]   LEVEL_HEIGHTS  = '0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        advance,
   input  logic [3:0]  level,
   output logic [31:0] row,
   output logic [31:0] col,
   output logic        last_col,
   output logic        last_row,
   output logic        last_level
);

   logic [31:0] max_col;
   logic [31:0] max_row;

   // Levels outside the table (e.g. the idle marker) give zero limits.
   always_comb begin
      max_col = '0;
      max_row = '0;
      for (int i = 0; i < PYRAMID_LEVELS; i++) begin
         if (level == 4'(i)) begin
            max_col = LEVEL_WIDTHS[i]  - 32'(WINDOW_SIZE) - 32'd1;
            max_row = LEVEL_HEIGHTS[i] - 32'(WINDOW_SIZE) - 32'd1;
         end
      end
   end

   assign last_col   = (col >= max_col);
   assign last_row   = (row >= max_row);
   assign last_level = (level == 4'(PYRAMID_LEVELS - 1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (!last_col) begin
            col <= col + 32'd1;
         end else if (!last_row) begin
            col <= '0;
            row <= row + 32'd1;
         end
      end
   end

endmodule

// File: rtl/scan_scheduler.sv
// Frame sequencer: load, integral-image refill wait, window scan per pyramid level, done pulse.
// First window INT_IMG_WAIT+2 cycles after img_rdy; scan advances only on win_valid && win_accept.
`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 2
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 24
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd27, 32'd30}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd26, 32'd28}
`endif

module scan_scheduler
   import vj_sched_pkg::*;
#(
   parameter int                                PYRAMID_LEVELS = `PYRAMID_LEVELS,
   parameter int                                WINDOW_SIZE    = `WINDOW_SIZE,
   parameter logic [PYRAMID_LEVELS-1:0][31:0]   LEVEL_WIDTHS   = `PYRAMID_WIDTHS,
   parameter logic [PYRAMID_LEVELS-1:0][31:0]   LEVEL_HEIGHTS  = `PYRAMID_HEIGHTS,
   parameter int                                INT_IMG_WAIT   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        img_rdy,
   input  logic        win_accept,
   output logic        load_img,
   output logic        downscale,
   output logic        win_valid,
   output logic [31:0] win_row,
   output logic [31:0] win_col,
   output logic [3:0]  level,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   sched_state_t state;
   sched_state_t next_state;
   logic [15:0]  wait_cnt;
   logic         accept;
   logic         last_col;
   logic         last_row;
   logic         last_level;

   assign accept = (state == SCAN) && win_accept;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (img_rdy) next_state = LOAD;
         LOAD:     next_state = WAIT_INT;
         WAIT_INT: if (wait_cnt == 16'(INT_IMG_WAIT - 1)) next_state = SCAN;
         SCAN: begin
            if (accept && last_col && last_row) begin
               next_state = last_level ? FIN : STEP;
            end
         end
         STEP:     next_state = WAIT_INT;
         FIN:      next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         level     <= LEVEL_IDLE;
         load_img  <= 1'b0;
         downscale <= 1'b0;
         win_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= next_state;
         wait_cnt  <= (state == WAIT_INT) ? wait_cnt + 16'd1 : '0;
         load_img  <= (next_state == LOAD);
         downscale <= (next_state == STEP);
         win_valid <= (next_state == SCAN);
         busy      <= (next_state != IDLE);
         done      <= (next_state == FIN);

         if (state == IDLE && img_rdy) begin
            level <= '0;
         end else if (next_state == STEP) begin
            level <= level + 4'd1;
         end else if (next_state == FIN) begin
            level <= LEVEL_IDLE;
         end

         // A new frame request clears the flag; any request while busy (FIN included) sets it.
         if (state == IDLE && img_rdy) begin
            overrun <= 1'b0;
         end else if (img_rdy) begin
            overrun <= 1'b1;
         end
      end
   end

   window_stepper #(
      .PYRAMID_LEVELS (PYRAMID_LEVELS),
      .WINDOW_SIZE    (WINDOW_SIZE),
      .LEVEL_WIDTHS   (LEVEL_WIDTHS),
      .LEVEL_HEIGHTS  (LEVEL_HEIGHTS)
   ) u_stepper (
      .clock      (clock),
      .reset      (reset),
      .clear      (next_state == WAIT_INT),
      .advance    (accept),
      .level      (level),
      .row        (win_row),
      .col        (win_col),
      .last_col   (last_col),
      .last_row   (last_row),
      .last_level (last_level)
   );

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler on a two-level 30x28 / 27x26 pyramid with a 24-pixel window.
module tb_scan_scheduler;

   localparam int NWIN = 30;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        img_rdy = 1'b0;
   logic        win_accept = 1'b0;
   logic        load_img, downscale, win_valid, busy, done, overrun;
   logic [31:0] win_row, win_col;
   logic [3:0]  level;

   int checks = 0;
   int errors = 0;
   int exp_row[$];
   int exp_col[$];
   int exp_lvl[$];

   always #5 clock = ~clock;

   scan_scheduler #(
      .PYRAMID_LEVELS (2),
      .WINDOW_SIZE    (24),
      .LEVEL_WIDTHS   ({32'd27, 32'd30}),
      .LEVEL_HEIGHTS  ({32'd26, 32'd28}),
      .INT_IMG_WAIT   (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .img_rdy    (img_rdy),
      .win_accept (win_accept),
      .load_img   (load_img),
      .downscale  (downscale),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .level      (level),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic build_expected;
      int w, h;
      for (int l = 0; l < 2; l++) begin
         w = (l == 0) ? 30 : 27;
         h = (l == 0) ? 28 : 26;
         for (int r = 0; r < h - 24; r++)
            for (int c = 0; c < w - 24; c++) begin
               exp_lvl.push_back(l);
               exp_row.push_back(r);
               exp_col.push_back(c);
            end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; img_rdy = 1'b0; win_accept = 1'b0;
      tick; tick;
      reset = 1'b0;
      checks++;
      if ({busy, win_valid, load_img, downscale, done, overrun} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000", {busy, win_valid, load_img, downscale, done, overrun});
      end
      checks++;
      if (level !== 4'd15) begin
         errors++; $display("FAIL reset_level got %0d want 15", level);
      end
      checks++;
      if (win_row !== 32'd0 || win_col !== 32'd0) begin
         errors++; $display("FAIL reset_coords got (%0d,%0d) want (0,0)", win_row, win_col);
      end
   endtask

   task automatic test_latency;
      int t;
      img_rdy = 1'b1;
      tick;
      img_rdy = 1'b0;
      t = 1;
      checks++;
      if (load_img !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL load_pulse got load=%b busy=%b want 1 1", load_img, busy);
      end
      while (win_valid !== 1'b1 && t < 20) begin
         tick;
         t++;
      end
      checks++;
      if (t != 5) begin
         errors++; $display("FAIL first_valid_cycle got %0d want 5", t);
      end
      checks++;
      if (win_row !== 32'd0 || win_col !== 32'd0 || level !== 4'd0) begin
         errors++; $display("FAIL first_window got (%0d,%0d,L%0d) want (0,0,L0)", win_row, win_col, level);
      end
      // No accept: the window must hold.
      tick; tick; tick;
      checks++;
      if (win_valid !== 1'b1 || win_row !== 32'd0 || win_col !== 32'd0 || level !== 4'd0) begin
         errors++; $display("FAIL idle_hold got v=%b (%0d,%0d,L%0d) want v=1 (0,0,L0)", win_valid, win_row, win_col, level);
      end
      reset = 1'b1; tick; reset = 1'b0;
   endtask

   task automatic test_full_frame;
      int n = 0, ds = 0, dn = 0, last0 = -1, first1 = -1, last_cyc = -1, done_cyc = -1, extra = 0;
      img_rdy = 1'b1; win_accept = 1'b1;
      tick;
      img_rdy = 1'b0;
      for (int cyc = 0; cyc < 200 && dn == 0; cyc++) begin
         if (win_valid === 1'b1) begin
            if (n < NWIN) begin
               checks++;
               if (win_row !== 32'(exp_row[n]) || win_col !== 32'(exp_col[n]) || level !== 4'(exp_lvl[n])) begin
                  errors++;
                  $display("FAIL frame_win%0d got (%0d,%0d,L%0d) want (%0d,%0d,L%0d)",
                           n, win_row, win_col, level, exp_row[n], exp_col[n], exp_lvl[n]);
               end
            end
            if (n == 23) last0 = cyc;
            if (n == 24) first1 = cyc;
            last_cyc = cyc;
            n++;
         end
         if (downscale === 1'b1) ds++;
         if (done === 1'b1) begin dn++; done_cyc = cyc; end
         tick;
      end
      win_accept = 1'b0;
      checks++;
      if (n != NWIN) begin errors++; $display("FAIL frame_count got %0d want %0d", n, NWIN); end
      checks++;
      if (ds != 1) begin errors++; $display("FAIL frame_downscale got %0d want 1", ds); end
      checks++;
      if (dn != 1) begin errors++; $display("FAIL frame_done got %0d want 1", dn); end
      checks++;
      if (first1 - last0 != 5) begin
         errors++; $display("FAIL level_gap got %0d want 5", first1 - last0);
      end
      checks++;
      if (done_cyc != last_cyc + 1) begin
         errors++; $display("FAIL done_timing got %0d want %0d", done_cyc, last_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0 || level !== 4'd15 || win_valid !== 1'b0) begin
         errors++; $display("FAIL frame_idle got busy=%b lvl=%0d v=%b want 0 15 0", busy, level, win_valid);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL extra_done got %0d want 0", extra); end
   endtask

   task automatic test_stall;
      int n = 0, dn = 0;
      logic a, pv, pa;
      logic [31:0] pr, pc;
      logic [3:0] pl;
      pv = 1'b0; pa = 1'b0; pr = '0; pc = '0; pl = '0;
      img_rdy = 1'b1;
      tick;
      img_rdy = 1'b0;
      for (int cyc = 0; cyc < 2000 && dn == 0; cyc++) begin
         if (pv && !pa) begin
            checks++;
            if (win_valid !== 1'b1 || win_row !== pr || win_col !== pc || level !== pl) begin
               errors++;
               $display("FAIL stall_hold got v=%b (%0d,%0d,L%0d) want v=1 (%0d,%0d,L%0d)",
                        win_valid, win_row, win_col, level, pr, pc, pl);
            end
         end
         a = 1'($urandom_range(0, 1));
         win_accept = a;
         if (win_valid === 1'b1 && a) begin
            if (n < NWIN) begin
               checks++;
               if (win_row !== 32'(exp_row[n]) || win_col !== 32'(exp_col[n]) || level !== 4'(exp_lvl[n])) begin
                  errors++;
                  $display("FAIL stall_win%0d got (%0d,%0d,L%0d) want (%0d,%0d,L%0d)",
                           n, win_row, win_col, level, exp_row[n], exp_col[n], exp_lvl[n]);
               end
            end
            n++;
         end
         pv = (win_valid === 1'b1); pa = a; pr = win_row; pc = win_col; pl = level;
         if (done === 1'b1) dn++;
         tick;
      end
      win_accept = 1'b0;
      checks++;
      if (n != NWIN) begin errors++; $display("FAIL stall_count got %0d want %0d", n, NWIN); end
      checks++;
      if (dn != 1) begin errors++; $display("FAIL stall_done got %0d want 1", dn); end
   endtask

   task automatic test_overrun;
      int n = 0, dn = 0;
      bit sent = 0, seen = 0;
      img_rdy = 1'b1; win_accept = 1'b1;
      tick;
      img_rdy = 1'b0;
      for (int cyc = 0; cyc < 200 && dn == 0; cyc++) begin
         img_rdy = 1'b0;
         if (sent && !seen) begin
            seen = 1;
            checks++;
            if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
         end
         if (win_valid === 1'b1) begin
            if (n < NWIN) begin
               checks++;
               if (win_row !== 32'(exp_row[n]) || win_col !== 32'(exp_col[n]) || level !== 4'(exp_lvl[n])) begin
                  errors++;
                  $display("FAIL ovr_win%0d got (%0d,%0d,L%0d) want (%0d,%0d,L%0d)",
                           n, win_row, win_col, level, exp_row[n], exp_col[n], exp_lvl[n]);
               end
            end
            if (n == 10) begin img_rdy = 1'b1; sent = 1; end
            n++;
         end
         if (done === 1'b1) dn++;
         tick;
      end
      img_rdy = 1'b0; win_accept = 1'b0;
      checks++;
      if (n != NWIN || dn != 1) begin
         errors++; $display("FAIL ovr_frame got n=%0d done=%0d want %0d 1", n, dn, NWIN);
      end
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL overrun_sticky got ovr=%b busy=%b want 1 0", overrun, busy);
      end
      img_rdy = 1'b1;
      tick;
      img_rdy = 1'b0;
      checks++;
      if (load_img !== 1'b1 || overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_clear got load=%b ovr=%b want 1 0", load_img, overrun);
      end
      reset = 1'b1; tick; reset = 1'b0;
   endtask

   task automatic test_reset_mid;
      int n = 0, dn = 0, vcnt = 0, t = 0;
      bit hit = 0;
      img_rdy = 1'b1; win_accept = 1'b1;
      tick;
      img_rdy = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         if (win_valid === 1'b1) begin
            if (n == 9) hit = 1;
            else n++;
         end
         if (!hit) tick;
      end
      checks++;
      if (!hit || win_row !== 32'd1 || win_col !== 32'd3 || level !== 4'd0) begin
         errors++; $display("FAIL tenth_window got hit=%0d (%0d,%0d,L%0d) want (1,3,L0)", hit, win_row, win_col, level);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0; win_accept = 1'b0;
      checks++;
      if (win_valid !== 1'b0 || level !== 4'd15 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mid_reset got v=%b lvl=%0d busy=%b done=%b want 0 15 0 0", win_valid, level, busy, done);
      end
      for (int i = 0; i < 10; i++) begin
         tick;
         if (done === 1'b1) dn++;
         if (win_valid === 1'b1) vcnt++;
      end
      checks++;
      if (dn != 0 || vcnt != 0) begin
         errors++; $display("FAIL post_reset got done=%0d valid=%0d want 0 0", dn, vcnt);
      end
      img_rdy = 1'b1;
      tick;
      img_rdy = 1'b0;
      t = 1;
      while (win_valid !== 1'b1 && t < 20) begin tick; t++; end
      checks++;
      if (t != 5 || win_row !== 32'd0 || win_col !== 32'd0 || level !== 4'd0) begin
         errors++; $display("FAIL restart got t=%0d (%0d,%0d,L%0d) want t=5 (0,0,L0)", t, win_row, win_col, level);
      end
   endtask

   initial begin
      build_expected();
      test_reset();
      test_latency();
      test_full_frame();
      test_stall();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
